// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - Common data bus arbiter: per-source writeback FIFOs, round-robin lane packing
package global_config_pkg;

  typedef struct packed {
    int unsigned ILEN;
  } cfg_t;

  localparam cfg_t Cfg = '{ILEN: 32};

endpackage

module cdb_arbiter #(
  parameter global_config_pkg::cfg_t Cfg = global_config_pkg::Cfg,
  parameter int DATA_W     = int'(Cfg.ILEN),
  parameter int TAG_W      = 6,
  parameter int NUM_SRC    = 6,
  parameter int NUM_CDB    = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_i,
  input  logic [NUM_SRC-1:0]   wb_valid,
  output logic [NUM_SRC-1:0]   wb_ready,
  input  logic [TAG_W-1:0]     wb_tag    [NUM_SRC],
  input  logic [DATA_W-1:0]    wb_val    [NUM_SRC],
  output logic [NUM_CDB-1:0]   cdb_valid,
  output logic [TAG_W-1:0]     cdb_tag   [NUM_CDB],
  output logic [DATA_W-1:0]    cdb_val   [NUM_CDB]
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int SRC_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int LANE_W = $clog2(NUM_CDB + 1);
  localparam int LIDX_W = (NUM_CDB > 1) ? $clog2(NUM_CDB) : 1;

  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [SRC_W:0]    NSRC_C    = (SRC_W + 1)'(NUM_SRC);
  localparam logic [SRC_W-1:0]  LAST_SRC  = SRC_W'(NUM_SRC - 1);
  localparam logic [LANE_W-1:0] NCDB_C    = LANE_W'(NUM_CDB);

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] val;
  } entry_t;

  // Per-source FIFO storage and bookkeeping
  entry_t            mem_q  [NUM_SRC][FIFO_DEPTH];
  logic [PTR_W-1:0]  head_q [NUM_SRC];
  logic [PTR_W-1:0]  head_d [NUM_SRC];
  logic [PTR_W-1:0]  tail_q [NUM_SRC];
  logic [PTR_W-1:0]  tail_d [NUM_SRC];
  logic [CNT_W-1:0]  cnt_q  [NUM_SRC];
  logic [CNT_W-1:0]  cnt_d  [NUM_SRC];
  logic [SRC_W-1:0]  rr_q;
  logic [SRC_W-1:0]  rr_d;

  entry_t            head_entry [NUM_SRC];
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] grant;
  logic               any_grant;
  logic [SRC_W-1:0]   last_src;
  logic [SRC_W:0]     scan;
  logic [LANE_W-1:0]  used;

  // Ready comes only from the registered count, so a same-cycle pop never opens the gate
  always_comb begin
    for (int s = 0; s < NUM_SRC; s++) begin
      wb_ready[s]   = (cnt_q[s] < DEPTH_C);
      push[s]       = wb_valid[s] & wb_ready[s] & ~flush_i;
      head_entry[s] = mem_q[s][head_q[s]];
    end
  end

  // Round-robin scan from rr_q, packing granted heads into the low lanes
  always_comb begin
    grant     = '0;
    cdb_valid = '0;
    any_grant = 1'b0;
    last_src  = rr_q;
    used      = '0;
    scan      = '0;
    for (int l = 0; l < NUM_CDB; l++) begin
      cdb_tag[l] = '0;
      cdb_val[l] = '0;
    end
    if (!flush_i) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        scan = {1'b0, rr_q} + (SRC_W + 1)'(k);
        if (scan >= NSRC_C) begin
          scan = scan - NSRC_C;
        end
        if ((cnt_q[scan[SRC_W-1:0]] != '0) && (used < NCDB_C)) begin
          grant[scan[SRC_W-1:0]]    = 1'b1;
          cdb_valid[LIDX_W'(used)]  = 1'b1;
          cdb_tag[LIDX_W'(used)]    = head_entry[scan[SRC_W-1:0]].tag;
          cdb_val[LIDX_W'(used)]    = head_entry[scan[SRC_W-1:0]].val;
          last_src                  = scan[SRC_W-1:0];
          any_grant                 = 1'b1;
          used                      = used + LANE_W'(1);
        end
      end
    end
  end

  // Next pointer/count per source; flush empties everything
  always_comb begin
    for (int s = 0; s < NUM_SRC; s++) begin
      head_d[s] = grant[s] ? head_q[s] + PTR_W'(1) : head_q[s];
      tail_d[s] = push[s]  ? tail_q[s] + PTR_W'(1) : tail_q[s];
      unique case ({push[s], grant[s]})
        2'b10:   cnt_d[s] = cnt_q[s] + CNT_W'(1);
        2'b01:   cnt_d[s] = cnt_q[s] - CNT_W'(1);
        default: cnt_d[s] = cnt_q[s];
      endcase
      if (flush_i) begin
        head_d[s] = '0;
        tail_d[s] = '0;
        cnt_d[s]  = '0;
      end
    end
  end

  // Pointer moves past the last granted source; idle cycles hold it
  always_comb begin
    if (flush_i) begin
      rr_d = '0;
    end else if (any_grant) begin
      rr_d = (last_src == LAST_SRC) ? '0 : last_src + SRC_W'(1);
    end else begin
      rr_d = rr_q;
    end
  end

  // Control state with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        head_q[s] <= '0;
        tail_q[s] <= '0;
        cnt_q[s]  <= '0;
      end
      rr_q <= '0;
    end else begin
      for (int s = 0; s < NUM_SRC; s++) begin
        head_q[s] <= head_d[s];
        tail_q[s] <= tail_d[s];
        cnt_q[s]  <= cnt_d[s];
      end
      rr_q <= rr_d;
    end
  end

  // Payload storage needs no reset; the counts gate every read
  always_ff @(posedge clk) begin
    for (int s = 0; s < NUM_SRC; s++) begin
      if (push[s]) begin
        mem_q[s][tail_q[s]] <= '{tag: wb_tag[s], val: wb_val[s]};
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - Directed vector bench for cdb_arbiter
module tb_cdb_arbiter;

  localparam int NS = 6;
  localparam int NC = 4;
  localparam int TW = 6;
  localparam int DW = 32;
  localparam int NV = 23;
  localparam logic [5:0] Z = 6'd0;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush_i = 1'b0;
  logic [NS-1:0] wb_valid = '0;
  logic [NS-1:0] wb_ready;
  logic [TW-1:0] wb_tag [NS];
  logic [DW-1:0] wb_val [NS];
  logic [NC-1:0] cdb_valid;
  logic [TW-1:0] cdb_tag [NC];
  logic [DW-1:0] cdb_val [NC];

  int n_chk = 0;
  int n_fail = 0;

  typedef struct packed {
    logic            fl;
    logic [5:0]      v;
    logic [5:0]      base;
    logic [3:0]      ev;
    logic [3:0][5:0] et;
    logic [5:0]      er;
  } vec_t;

  vec_t vec [NV];

  always #5 clk = ~clk;

  cdb_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush_i  (flush_i),
    .wb_valid (wb_valid),
    .wb_ready (wb_ready),
    .wb_tag   (wb_tag),
    .wb_val   (wb_val),
    .cdb_valid(cdb_valid),
    .cdb_tag  (cdb_tag),
    .cdb_val  (cdb_val)
  );

  function automatic logic [3:0][5:0] t4(input logic [5:0] a, input logic [5:0] b,
                                         input logic [5:0] c, input logic [5:0] d);
    logic [3:0][5:0] r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d;
    return r;
  endfunction

  function automatic vec_t mk(input logic fl, input logic [5:0] v, input logic [5:0] base,
                              input logic [3:0] ev, input logic [3:0][5:0] et);
    vec_t r;
    r.fl = fl; r.v = v; r.base = base; r.ev = ev; r.et = et; r.er = 6'h3f;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic bad(input string nm, input logic [31:0] act);
    n_chk++;
    n_fail++;
    $display("FAIL %s: actual %0h", nm, act);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t x);
    logic [5:0] t;
    flush_i = x.fl;
    for (int s = 0; s < NS; s++) begin
      t = x.base + 6'(s);
      wb_valid[s] = x.v[s];
      wb_tag[s]   = t;
      wb_val[s]   = 32'hA500_0000 | {26'd0, t};
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, elapsed %0t", $time);
    $fatal(1);
  end

  logic [31:0] sb [NS][16];
  int          wr [NS];
  int          rd [NS];
  int          seq [NS];
  int          wait_c [NS];

  initial begin
    logic [5:0]    et;
    logic [31:0]   ev32;
    logic [NS-1:0] had;
    logic [NS-1:0] granted;
    logic [3:0]    mask;
    int            ne;
    int            src;
    int            cyc;
    bit            saw_not_ready;

    vec[0]  = mk(1'b0, 6'b000000, 6'd0,  4'b0000, t4(Z, Z, Z, Z));
    vec[1]  = mk(1'b0, 6'b000001, 6'd5,  4'b0000, t4(Z, Z, Z, Z));
    vec[2]  = mk(1'b0, 6'b000000, 6'd0,  4'b0001, t4(6'd5, Z, Z, Z));
    vec[3]  = mk(1'b0, 6'b100010, 6'd10, 4'b0000, t4(Z, Z, Z, Z));
    vec[4]  = mk(1'b0, 6'b000000, 6'd0,  4'b0011, t4(6'd11, 6'd15, Z, Z));
    vec[5]  = mk(1'b0, 6'b111111, 6'd1,  4'b0000, t4(Z, Z, Z, Z));
    vec[6]  = mk(1'b0, 6'b000000, 6'd0,  4'b1111, t4(6'd1, 6'd2, 6'd3, 6'd4));
    vec[7]  = mk(1'b0, 6'b000000, 6'd0,  4'b0011, t4(6'd5, 6'd6, Z, Z));
    vec[8]  = mk(1'b0, 6'b010000, 6'd16, 4'b0000, t4(Z, Z, Z, Z));
    vec[9]  = mk(1'b0, 6'b000000, 6'd0,  4'b0001, t4(6'd20, Z, Z, Z));
    vec[10] = mk(1'b0, 6'b100001, 6'd30, 4'b0000, t4(Z, Z, Z, Z));
    vec[11] = mk(1'b0, 6'b000000, 6'd0,  4'b0011, t4(6'd35, 6'd30, Z, Z));
    vec[12] = mk(1'b0, 6'b000011, 6'd40, 4'b0000, t4(Z, Z, Z, Z));
    vec[13] = mk(1'b0, 6'b000000, 6'd0,  4'b0011, t4(6'd41, 6'd40, Z, Z));
    vec[14] = mk(1'b0, 6'b000100, 6'd50, 4'b0000, t4(Z, Z, Z, Z));
    vec[15] = mk(1'b0, 6'b000100, 6'd50, 4'b0001, t4(6'd52, Z, Z, Z));
    vec[16] = mk(1'b0, 6'b000000, 6'd0,  4'b0001, t4(6'd52, Z, Z, Z));
    vec[17] = mk(1'b0, 6'b001001, 6'd60, 4'b0000, t4(Z, Z, Z, Z));
    vec[18] = mk(1'b1, 6'b111111, 6'd1,  4'b0000, t4(Z, Z, Z, Z));
    vec[19] = mk(1'b0, 6'b000000, 6'd0,  4'b0000, t4(Z, Z, Z, Z));
    vec[20] = mk(1'b0, 6'b000000, 6'd0,  4'b0000, t4(Z, Z, Z, Z));
    vec[21] = mk(1'b0, 6'b100001, 6'd24, 4'b0000, t4(Z, Z, Z, Z));
    vec[22] = mk(1'b0, 6'b000000, 6'd0,  4'b0011, t4(6'd24, 6'd29, Z, Z));

    for (int s = 0; s < NS; s++) begin
      wb_tag[s] = '0;
      wb_val[s] = '0;
    end

    // Reset held: outputs must already be quiet
    #2;
    chk("reset valid", 32'(cdb_valid), 32'h0);
    chk("reset ready", 32'(wb_ready), 32'h3f);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Table of single-cycle vectors
    for (int r = 0; r < NV; r++) begin
      apply(vec[r]);
      #1;
      chk($sformatf("row%0d valid", r), 32'(cdb_valid), 32'(vec[r].ev));
      chk($sformatf("row%0d ready", r), 32'(wb_ready), 32'(vec[r].er));
      for (int l = 0; l < NC; l++) begin
        et   = vec[r].et[l];
        ev32 = vec[r].ev[l] ? (32'hA500_0000 | {26'd0, et}) : 32'h0;
        chk($sformatf("row%0d lane%0d tag", r, l), 32'(cdb_tag[l]), 32'(et));
        chk($sformatf("row%0d lane%0d val", r, l), cdb_val[l], ev32);
      end
      tick();
    end

    // Saturation: every source offers a result each cycle for 10 cycles
    flush_i = 1'b0;
    wb_valid = '0;
    saw_not_ready = 1'b0;
    for (int s = 0; s < NS; s++) begin
      wr[s] = 0; rd[s] = 0; seq[s] = 0; wait_c[s] = 0;
    end
    cyc = 0;
    while (cyc < 40) begin
      ne = 0;
      for (int s = 0; s < NS; s++) if (wr[s] != rd[s]) ne++;
      if (cyc >= 10 && ne == 0) break;
      for (int s = 0; s < NS; s++) begin
        wb_valid[s] = (cyc < 10);
        wb_tag[s]   = 6'(s);
        wb_val[s]   = {8'(s), 24'(seq[s])};
      end
      #1;
      for (int s = 0; s < NS; s++) begin
        chk($sformatf("sat c%0d ready%0d", cyc, s), 32'(wb_ready[s]), 32'((wr[s] - rd[s]) < 2));
        had[s] = (wr[s] != rd[s]);
      end
      if (wb_ready != 6'h3f) saw_not_ready = 1'b1;
      mask = 4'((1 << ((ne < NC) ? ne : NC)) - 1);
      chk($sformatf("sat c%0d valid", cyc), 32'(cdb_valid), 32'(mask));
      granted = '0;
      for (int l = 0; l < NC; l++) begin
        if (cdb_valid[l]) begin
          src = int'(cdb_val[l][31:24]);
          if (src >= NS) begin
            bad($sformatf("sat c%0d lane%0d bad source", cyc, l), cdb_val[l]);
          end else if (wr[src] == rd[src] || granted[src]) begin
            bad($sformatf("sat c%0d lane%0d unexpected entry", cyc, l), cdb_val[l]);
          end else begin
            chk($sformatf("sat c%0d lane%0d val", cyc, l), cdb_val[l], sb[src][rd[src]]);
            chk($sformatf("sat c%0d lane%0d tag", cyc, l), 32'(cdb_tag[l]), 32'(src));
            rd[src]++;
            granted[src] = 1'b1;
          end
        end
      end
      for (int s = 0; s < NS; s++) begin
        wait_c[s] = (had[s] && !granted[s]) ? wait_c[s] + 1 : 0;
        chk($sformatf("sat c%0d wait%0d", cyc, s), 32'(wait_c[s] <= 2), 32'h1);
      end
      for (int s = 0; s < NS; s++) begin
        if (wb_valid[s] && wb_ready[s]) begin
          sb[s][wr[s]] = wb_val[s];
          wr[s]++;
          seq[s]++;
        end
      end
      tick();
      cyc++;
    end
    wb_valid = '0;
    for (int s = 0; s < NS; s++) begin
      chk($sformatf("sat drained%0d", s), 32'(rd[s]), 32'(wr[s]));
    end
    chk("sat backpressure seen", 32'(saw_not_ready), 32'h1);

    // Asynchronous reset while four sources are busy
    for (int s = 0; s < NS; s++) begin
      wb_valid[s] = (s < 4);
      wb_tag[s]   = 6'(40 + s);
      wb_val[s]   = 32'hA500_0000 | 32'(40 + s);
    end
    tick();
    #1;
    chk("busy before reset", 32'(cdb_valid), 32'hf);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async reset valid", 32'(cdb_valid), 32'h0);
    chk("async reset ready", 32'(wb_ready), 32'h3f);
    chk("async reset tag0", 32'(cdb_tag[0]), 32'h0);
    chk("async reset val0", cdb_val[0], 32'h0);
    wb_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    wb_valid[0] = 1'b1;
    wb_tag[0]   = 6'd9;
    wb_val[0]   = 32'hDEADBEEF;
    tick();
    wb_valid = '0;
    #1;
    chk("post reset valid", 32'(cdb_valid), 32'h1);
    chk("post reset tag", 32'(cdb_tag[0]), 32'd9);
    chk("post reset val", cdb_val[0], 32'hDEADBEEF);
    tick();
    #1;
    chk("post reset drained", 32'(cdb_valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Producer side of the common data bus. Collects writeback results from NUM_SRC functional units (ALUs, LSU, MUL/DIV, BRU) through valid/ready handshakes. Buffers each source in a small FIFO and broadcasts up to NUM_CDB results per cycle on the `cdb_valid`/`cdb_tag`/`cdb_val` lanes that the issue queue and ROB consume for wakeup and completion. Lanes are granted among sources by round-robin.

## Interface
Parameters:
- Cfg, global_config_pkg::Cfg, global configuration record
- DATA_W, Cfg.ILEN, result value width
- TAG_W, 6, physical destination tag width
- NUM_SRC, 6, number of writeback sources
- NUM_CDB, 4, number of CDB lanes
- FIFO_DEPTH, 2, entries per source FIFO (power of two, ≥2)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush_i  in  1  synchronous pipeline flush
- wb_valid  in  NUM_SRC  per-source result valid
- wb_ready  out  NUM_SRC  per-source FIFO can accept
- wb_tag  in  TAG_W × [0:NUM_SRC-1]  destination tag per source
- wb_val  in  DATA_W × [0:NUM_SRC-1]  result value per source
- cdb_valid  out  NUM_CDB  lane valid
- cdb_tag  out  TAG_W × [0:NUM_CDB-1]  lane tag
- cdb_val  out  DATA_W × [0:NUM_CDB-1]  lane value

## Operation
- Per-source FIFO: head/tail pointers of width log2(FIFO_DEPTH) that wrap modulo FIFO_DEPTH, plus a count register of width log2(FIFO_DEPTH)+1.
- Push: when `wb_valid[s] && wb_ready[s]` and `!flush_i`, capture {wb_tag, wb_val} at the tail.
- wb_ready[s] = (count[s] < FIFO_DEPTH).
  - Depends only on registered count.
  - A same-cycle pop does not raise ready.
- Arbitration is combinational from FIFO heads:
  - Scan sources rr_ptr, rr_ptr+1, … (mod NUM_SRC).
  - Grant the first min(NUM_CDB, #non-empty) non-empty sources.
  - At most one entry per source per cycle.
- Lane packing:
  - Granted heads fill lanes 0,1,2,… in scan order.
  - cdb_valid is therefore always a contiguous low-bit mask (0000, 0001, 0011, 0111, 1111).
  - Ungranted lanes drive cdb_tag = 0 and cdb_val = 0.
- Pop: every granted source pops its head at the end of the cycle. Downstream has no backpressure; a broadcast is always consumed.
- Round-robin pointer:
  - rr_ptr ∈ [0, NUM_SRC-1].
  - If any grant occurs, rr_ptr ← (last granted source + 1) mod NUM_SRC; otherwise it holds.
- Simultaneous push and pop on the same source: count unchanged, both pointers advance.
- Flush:
  - While flush_i = 1, cdb_valid = 0 and no pops or pushes occur.
  - At that edge, all FIFOs empty and rr_ptr ← 0.
  - wb_valid presented during the flush cycle is dropped.
- Ordering: per-source FIFO order is preserved on the CDB. No cross-source ordering is guaranteed.

## Timing
- Reset (async assert, any time):
  - All FIFOs are emptied and rr_ptr = 0.
  - Outputs take these values immediately: cdb_valid = 0, cdb_tag/cdb_val = 0, wb_ready = all 1.
- Latency:
  - A result accepted at edge N can appear on the CDB in cycle N+1 at the earliest. There is no combinational wb→cdb path.
  - It leaves the FIFO at edge N+1 if granted.
- Throughput: NUM_CDB results per cycle aggregate, 1 per source per cycle.
- A full source whose entry is popped at edge N shows wb_ready = 1 in cycle N+1.
- Reset deassertion: the first push is accepted at the first rising edge with rst_n = 1.

## Test plan
- Single result: src0 pushes tag 5, val 0xDEADBEEF at edge 0.
  - Cycle 1: cdb_valid = 0001, cdb_tag[0] = 5, cdb_val[0] = 0xDEADBEEF.
  - Cycle 2: cdb_valid = 0000 and rr_ptr = 1.
- Oversubscription: all 6 sources push tags 1..6 at edge 0, rr_ptr = 0.
  - Cycle 1: lanes carry tags 1,2,3,4 with valid = 1111.
  - Cycle 2: lanes 0,1 carry tags 5,6 with valid = 0011; rr_ptr ends at 0.
- Rotation: sources 0 and 5 both non-empty with rr_ptr = 5 → lane 0 = src5 head and lane 1 = src0 head; rr_ptr ← 1.
- Saturation/backpressure: all 6 sources hold wb_valid = 1 for 10 cycles, each with a per-source incrementing val.
  - Some wb_ready bits deassert.
  - cdb_valid = 1111 every cycle from 1 until drained.
  - Every accepted result appears exactly once, in per-source order.
  - No source waits more than 2 consecutive grant rounds.
- Flush: fill src0 and src3 to 2 entries each, then assert flush_i for 1 cycle.
  - Flush cycle: cdb_valid = 0.
  - Next cycle: cdb_valid = 0 and wb_ready = 111111.
  - A push during the flush cycle never appears on the CDB.
- Async reset mid-traffic: drop rst_n between edges while 4 sources are busy → cdb_valid = 0 before the next edge. After release, one push of tag 9 appears alone one cycle later.
